// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and mode constants for the serial arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit full adder from two half-adder stages and an OR for carry
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p, g1, g2;
  assign p    = x ^ y;
  assign g1   = x & y;
  assign s    = p ^ cin;
  assign g2   = p & cin;
  assign cout = g1 | g2;
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract of two WIDTH-bit operands, one bit per clock
module serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cmsb_q, cmsb_d, co_q, co_d, ov_q, ov_d;
  logic fa_s, fa_c;
  full_adder_cell u_fa (.x(a_q[0]), .y(b_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_c));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = (sub == MODE_SUB) ? ~b : b;
        carry_d = sub;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        ps_d    = {fa_s, ps_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        // carry_q here is the carry into the MSB, kept for the overflow test
        cmsb_d  = (cnt_q == LAST) ? carry_q : cmsb_q;
        state_d = (cnt_q == LAST) ? DONE : SHIFT;
      end
      DONE: begin
        sum_d   = ps_q;
        co_d    = carry_q;
        ov_d    = cmsb_q ^ carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule
